// File: rtl/sc_result_pair_acc.sv
// Pairs channel-1/channel-2 popcount results, accumulates their signed difference over FRAMES
// pairs and queues each frame decision in a 2-entry valid/ready output buffer.
module sc_result_pair_acc #(
    parameter int unsigned FRAMES = 4,
    parameter int unsigned ACC_W  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_in1,
    input  logic [8:0]       result1,
    input  logic             en_in2,
    input  logic [8:0]       result2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_class,
    output logic             err_pair,
    output logic             err_ovf
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StHold1 = 2'd1;
    localparam logic [1:0] StHold2 = 2'd2;

    localparam logic [3:0] LastFrame = 4'(FRAMES - 1);

    logic [1:0]              state_q, state_d;
    logic [8:0]              hold_q, hold_d;
    logic                    pair_vld;
    logic [8:0]              pair_r1, pair_r2;
    logic                    err_pair_set;
    logic signed [9:0]       diff;
    logic signed [ACC_W-1:0] acc_q, acc_sum;
    logic [3:0]              frame_cnt_q;
    logic                    push, pop, full, push_ok;
    logic [ACC_W-1:0]        mem_q [2];
    logic                    rd_ptr_q, wr_ptr_q;
    logic [1:0]              count_q;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        pair_vld     = 1'b0;
        pair_r1      = result1;
        pair_r2      = result2;
        err_pair_set = 1'b0;
        case (state_q)
            StHold1: begin
                pair_r1 = hold_q;
                if (en_in2) begin
                    pair_vld = 1'b1;
                    // A fresh result1 arriving with the partner starts the next pair.
                    if (en_in1) hold_d = result1;
                    else        state_d = StIdle;
                end else if (en_in1) begin
                    err_pair_set = 1'b1;
                end
            end
            StHold2: begin
                pair_r2 = hold_q;
                if (en_in1) begin
                    pair_vld = 1'b1;
                    if (en_in2) hold_d = result2;
                    else        state_d = StIdle;
                end else if (en_in2) begin
                    err_pair_set = 1'b1;
                end
            end
            default: begin
                if (en_in1 && en_in2) begin
                    pair_vld = 1'b1;
                end else if (en_in1) begin
                    hold_d  = result1;
                    state_d = StHold1;
                end else if (en_in2) begin
                    hold_d  = result2;
                    state_d = StHold2;
                end
            end
        endcase
    end

    always_comb begin
        diff    = $signed({1'b0, pair_r1}) - $signed({1'b0, pair_r2});
        acc_sum = acc_q + ACC_W'(diff);
        push    = pair_vld && (frame_cnt_q == LastFrame);
        pop     = out_valid && out_ready;
        full    = (count_q == 2'd2);
        // A pop on the same edge frees the slot, so a full buffer still accepts the push.
        push_ok = push && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            acc_q       <= '0;
            frame_cnt_q <= '0;
            err_pair    <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            if (err_pair_set) err_pair <= 1'b1;
            if (push && !push_ok) err_ovf <= 1'b1;
            if (pair_vld) begin
                if (push) begin
                    acc_q       <= '0;
                    frame_cnt_q <= '0;
                end else begin
                    acc_q       <= acc_sum;
                    frame_cnt_q <= frame_cnt_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= acc_sum;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push_ok} - {1'b0, pop};
        end
    end

    always_comb begin
        out_valid = (count_q != 2'd0);
        out_sum   = mem_q[rd_ptr_q];
        out_class = mem_q[rd_ptr_q][ACC_W-1];
    end

endmodule

// File: tb/tb_sc_result_pair_acc.sv
// Self-checking bench: directed vectors on FRAMES=4 and FRAMES=1 instances, then random
// stimulus compared against a queue-based reference model.
module tb_sc_result_pair_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        en1 [2];
    logic        en2 [2];
    logic [8:0]  r1  [2];
    logic [8:0]  r2  [2];
    logic        rdy [2];
    logic        vld [2];
    logic [11:0] sum [2];
    logic        cls [2];
    logic        ep  [2];
    logic        eo  [2];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sc_result_pair_acc #(.FRAMES(4), .ACC_W(12)) u_dut4 (
        .clk(clk), .rst(rst),
        .en_in1(en1[0]), .result1(r1[0]), .en_in2(en2[0]), .result2(r2[0]),
        .out_valid(vld[0]), .out_ready(rdy[0]), .out_sum(sum[0]), .out_class(cls[0]),
        .err_pair(ep[0]), .err_ovf(eo[0])
    );

    sc_result_pair_acc #(.FRAMES(1), .ACC_W(12)) u_dut1 (
        .clk(clk), .rst(rst),
        .en_in1(en1[1]), .result1(r1[1]), .en_in2(en2[1]), .result2(r2[1]),
        .out_valid(vld[1]), .out_ready(rdy[1]), .out_sum(sum[1]), .out_class(cls[1]),
        .err_pair(ep[1]), .err_ovf(eo[1])
    );

    // Reference model: pending strobe, list of the current frame's differences, decision queue.
    bit m_pend [2];
    int m_pch  [2];
    int m_hv   [2];
    int m_frame [2][$];
    int m_fifo  [2][$];
    bit m_ep   [2];
    bit m_eo   [2];

    function automatic int frames_of(int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic void model_step(int k);
        int a, b, s;
        bit pair, pop;
        int v1, v2;
        v1 = int'(r1[k]);
        v2 = int'(r2[k]);
        if (rst) begin
            m_pend[k] = 0;
            m_frame[k].delete();
            m_fifo[k].delete();
            m_ep[k] = 0;
            m_eo[k] = 0;
            return;
        end
        pair = 0; a = 0; b = 0;
        pop  = (m_fifo[k].size() > 0) && rdy[k];
        if (!m_pend[k]) begin
            if (en1[k] && en2[k]) begin pair = 1; a = v1; b = v2; end
            else if (en1[k]) begin m_pend[k] = 1; m_pch[k] = 1; m_hv[k] = v1; end
            else if (en2[k]) begin m_pend[k] = 1; m_pch[k] = 2; m_hv[k] = v2; end
        end else if (m_pch[k] == 1) begin
            if (en2[k]) begin
                pair = 1; a = m_hv[k]; b = v2;
                if (en1[k]) m_hv[k] = v1; else m_pend[k] = 0;
            end else if (en1[k]) m_ep[k] = 1;
        end else begin
            if (en1[k]) begin
                pair = 1; a = v1; b = m_hv[k];
                if (en2[k]) m_hv[k] = v2; else m_pend[k] = 0;
            end else if (en2[k]) m_ep[k] = 1;
        end
        if (pop) void'(m_fifo[k].pop_front());
        if (pair) begin
            m_frame[k].push_back(a - b);
            if (m_frame[k].size() == frames_of(k)) begin
                s = 0;
                for (int i = 0; i < m_frame[k].size(); i++) s += m_frame[k][i];
                m_frame[k].delete();
                if (m_fifo[k].size() < 2) m_fifo[k].push_back(s);
                else m_eo[k] = 1;
            end
        end
    endfunction

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int ssum(int k);
        return int'($signed(sum[k]));
    endfunction

    task automatic drive(int k, bit e1, int v1, bit e2, int v2);
        en1[k] = e1; r1[k] = 9'(v1);
        en2[k] = e2; r2[k] = 9'(v2);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        for (int k = 0; k < 2; k++) begin en1[k] = 1'b0; en2[k] = 1'b0; end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        bit e1; int v1; bit e2; int v2; bit rdy;
        bit exp_vld; int exp_sum;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{1'b1, 300, 1'b1, 100, 1'b1, 1'b0, 0};
        tbl[1] = '{1'b1, 200, 1'b1, 250, 1'b1, 1'b0, 0};
        tbl[2] = '{1'b1, 511, 1'b1, 0,   1'b1, 1'b0, 0};
        tbl[3] = '{1'b1, 0,   1'b1, 0,   1'b1, 1'b1, 661};
        tbl[4] = '{1'b0, 0,   1'b0, 0,   1'b1, 1'b0, 0};
        tbl[5] = '{1'b0, 0,   1'b0, 0,   1'b1, 1'b0, 0};

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin drive(k, 0, 0, 0, 0); rdy[k] = 1'b0; end
        cycle();
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("reset_valid", vld[k], 0);
            check("reset_sum", ssum(k), 0);
            check("reset_class", cls[k], 0);
            check("reset_err_pair", ep[k], 0);
            check("reset_err_ovf", eo[k], 0);
        end

        // Four simultaneous pairs on FRAMES=4.
        for (int i = 0; i < 6; i++) begin
            rdy[0] = tbl[i].rdy;
            drive(0, tbl[i].e1, tbl[i].v1, tbl[i].e2, tbl[i].v2);
            cycle();
            check("tbl_valid", vld[0], int'(tbl[i].exp_vld));
            if (tbl[i].exp_vld) begin
                check("tbl_sum", ssum(0), tbl[i].exp_sum);
                check("tbl_class", cls[0], int'(tbl[i].exp_sum < 0));
            end
        end

        // Skewed arrival on FRAMES=1.
        rdy[1] = 1'b1;
        drive(1, 0, 0, 1, 400);
        cycle();
        check("skew_early_valid", vld[1], 0);
        cycle();
        cycle();
        drive(1, 1, 100, 0, 0);
        cycle();
        check("skew_valid", vld[1], 1);
        check("skew_sum", ssum(1), -300);
        check("skew_class", cls[1], 1);
        check("skew_err_pair", ep[1], 0);
        check("skew_err_ovf", eo[1], 0);
        cycle();
        check("skew_drained", vld[1], 0);

        // Double strobe: second channel-1 value is dropped.
        drive(1, 1, 50, 0, 0);
        cycle();
        drive(1, 1, 70, 0, 0);
        cycle();
        check("dbl_err_pair", ep[1], 1);
        drive(1, 0, 0, 1, 20);
        cycle();
        check("dbl_valid", vld[1], 1);
        check("dbl_sum", ssum(1), 30);
        cycle();

        // Backpressure: third decision overflows.
        reset_dut();
        check("rst_clears_err_pair", ep[1], 0);
        rdy[1] = 1'b0;
        drive(1, 1, 1, 1, 0);
        cycle();
        check("bp_valid1", vld[1], 1);
        check("bp_sum1", ssum(1), 1);
        drive(1, 1, 2, 1, 0);
        cycle();
        check("bp_head_stable", ssum(1), 1);
        check("bp_no_ovf_yet", eo[1], 0);
        drive(1, 1, 3, 1, 0);
        cycle();
        check("bp_err_ovf", eo[1], 1);
        check("bp_head_after_ovf", ssum(1), 1);
        rdy[1] = 1'b1;
        cycle();
        check("bp_pop_valid", vld[1], 1);
        check("bp_pop_sum2", ssum(1), 2);
        cycle();
        check("bp_empty", vld[1], 0);

        // Full buffer with push and pop on the same edge.
        reset_dut();
        rdy[1] = 1'b0;
        drive(1, 1, 5, 1, 0);
        cycle();
        drive(1, 1, 6, 1, 0);
        cycle();
        rdy[1] = 1'b1;
        drive(1, 1, 7, 1, 0);
        cycle();
        check("pp_no_ovf", eo[1], 0);
        check("pp_head", ssum(1), 6);
        cycle();
        check("pp_new_kept", ssum(1), 7);
        check("pp_new_valid", vld[1], 1);
        cycle();
        check("pp_empty", vld[1], 0);

        // Reset mid-frame with a HOLD1 pending and a strobe on the reset edge.
        rdy[0] = 1'b1;
        drive(0, 1, 10, 1, 0);
        cycle();
        drive(0, 1, 20, 1, 0);
        cycle();
        drive(0, 1, 100, 0, 0);
        cycle();
        drive(0, 1, 110, 0, 0);
        cycle();
        check("mid_err_pair", ep[0], 1);
        rst = 1'b1;
        drive(0, 0, 0, 1, 200);
        cycle();
        rst = 1'b0;
        check("mid_rst_valid", vld[0], 0);
        check("mid_rst_sum", ssum(0), 0);
        check("mid_rst_class", cls[0], 0);
        check("mid_rst_err_pair", ep[0], 0);
        check("mid_rst_err_ovf", eo[0], 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 4, 1, 1);
            cycle();
        end
        check("mid_post_valid", vld[0], 1);
        check("mid_post_sum", ssum(0), 12);

        // Random phases against the reference model.
        for (int ph = 0; ph < 4; ph++) begin
            reset_dut();
            for (int c = 0; c < 150; c++) begin
                for (int k = 0; k < 2; k++) begin
                    if (ph == 0) begin
                        bit both;
                        both = ($urandom_range(0, 1) == 1);
                        drive(k, both, $urandom_range(0, 511), both, $urandom_range(0, 511));
                    end else begin
                        drive(k, ($urandom_range(0, 2) != 0), $urandom_range(0, 511),
                              ($urandom_range(0, 2) != 0), $urandom_range(0, 511));
                    end
                    rdy[k] = (ph == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                end
                cycle();
                for (int k = 0; k < 2; k++) begin
                    check("rand_valid", vld[k], int'(m_fifo[k].size() > 0));
                    if (m_fifo[k].size() > 0) begin
                        check("rand_sum", ssum(k), m_fifo[k][0]);
                        check("rand_class", cls[k], int'(m_fifo[k][0] < 0));
                    end
                    check("rand_err_pair", ep[k], int'(m_ep[k]));
                    check("rand_err_ovf", eo[k], int'(m_eo[k]));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sc_result_pair_acc.md
# sc_result_pair_acc

Downstream stage of the stochastic-computing datapath. It takes the two 9-bit popcount results from the two four-input ADD units (channel 1 and channel 2), each with its own completion strobe. It pairs one result from each channel and accumulates the signed difference over `FRAMES` pairs. It then pushes a frame decision (accumulated sum plus winning channel) into a 2-entry output buffer, which drains through a valid/ready handshake.

## Interface
Parameters:
- `FRAMES`, default 4: number of result pairs accumulated per decision; legal range 1–16.
- `ACC_W`, default 12: signed accumulator width. Must be ≥ 10 + ceil(log2(FRAMES)), so overflow is impossible.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `en_in1` in 1: one-cycle strobe, `result1` valid (from the channel-1 ADD `en_out`).
- `result1` in 9: unsigned channel-1 count, 0–511.
- `en_in2` in 1: one-cycle strobe, `result2` valid.
- `result2` in 9: unsigned channel-2 count.
- `out_valid` out 1: buffer head holds a decision.
- `out_ready` in 1: consumer accepts the head when `out_valid && out_ready`.
- `out_sum` out ACC_W: signed Σ(result1 − result2) over the frame.
- `out_class` out 1: 0 if `out_sum` ≥ 0 (channel 1 wins), 1 otherwise.
- `err_pair` out 1: sticky; a channel strobed twice before its partner arrived.
- `err_ovf` out 1: sticky; a frame completed while the buffer was full and not popping.

## Operation
Pairing FSM, 3 states, evaluated at each rising edge:
- IDLE:
  - `en_in1 && en_in2`: pair is formed this edge; stay in IDLE.
  - only `en_in1`: latch `result1` into `hold`; go to HOLD1.
  - only `en_in2`: latch `result2` into `hold`; go to HOLD2.
- HOLD1:
  - `en_in2`: pair is (`hold`, `result2`); go to IDLE.
  - `en_in1` without `en_in2`: drop the new value, keep `hold`, set `err_pair`, stay in HOLD1.
  - `en_in1 && en_in2` together: pair is (`hold`, `result2`); the new `result1` is latched; stay in HOLD1.
- HOLD2: mirror of HOLD1 with the channels swapped.

Accumulation, on every edge where a pair forms:
- d = zero-extended r1 − zero-extended r2, 10-bit signed, range −511…+511.
- If `frame_cnt` < FRAMES−1: `acc <= acc + d`, `frame_cnt++`.
- If `frame_cnt` == FRAMES−1: frame completes.
  - Push {`acc + d`, sign(`acc + d`)} into the buffer.
  - `acc <= 0`, `frame_cnt <= 0`.

Output buffer, 2-entry FIFO:
- Head drives `out_sum` and `out_class`.
- A pop occurs on any edge with `out_valid && out_ready`.
- Push and pop on the same edge: allowed at any occupancy, including full; occupancy is unchanged.
- Push when full with no pop: the new decision is discarded and `err_ovf` is set; `acc` and `frame_cnt` still clear.
- `out_ready` while empty: no effect.
- `out_sum` and `out_class` hold their values while `out_valid` is low; they are don't-care for checking.

Reset, synchronous, takes priority over all other activity including a mid-frame pair:
- FSM to IDLE; `hold`, `acc` and `frame_cnt` to 0.
- FIFO emptied.
- `out_valid`, `out_sum`, `out_class`, `err_pair` and `err_ovf` all 0.

## Timing
- Pair formation, accumulation and push all happen at the edge where the second strobe is sampled. There is no combinational path from `en_in*` to outputs.
- Latency: `out_valid` rises in the cycle after the edge that sampled the frame's final pairing strobe, i.e. 1 cycle.
- Head is stable while `out_valid && !out_ready`.
- After a pop, the next entry is presented on the following cycle; back-to-back pops drain the buffer at 1 entry/cycle.
- Throughput: one pair per cycle, provided both strobes arrive together every cycle.
- `err_*` flags assert the cycle after the offending edge and clear only on `rst`.

## Test plan
- FRAMES=4, simultaneous strobes:
  - Stimulus: pairs (300,100), (200,250), (511,0), (0,0), `out_ready`=1.
  - Response: one decision, `out_sum`=661, `out_class`=0, `out_valid` high for exactly 1 cycle, 1 cycle after the 4th strobe.
- Skewed arrival, FRAMES=1:
  - Stimulus: `en_in2` (result2=400), then `en_in1` (result1=100) 3 cycles later.
  - Response: `out_sum`=−300, `out_class`=1; no error flags.
- Double strobe, FRAMES=1:
  - Stimulus: `en_in1` (50), then `en_in1` (70), then `en_in2` (20).
  - Response: `err_pair`=1; `out_sum`=30, since the 70 is dropped.
- Backpressure, FRAMES=1, `out_ready`=0:
  - Stimulus: complete three frames with d=+1, +2, +3.
  - Response: buffer holds 1 then 2; `err_ovf`=1.
  - Then raise `out_ready`: response is `out_sum` 1 then 2 on consecutive cycles, then `out_valid`=0.
- Full buffer with simultaneous push and pop:
  - Stimulus: buffer full, `out_ready`=1 on the same edge a frame completes.
  - Response: no `err_ovf`; the new entry is retained.
- Reset mid-frame:
  - Stimulus: `rst` asserted after 2 of 4 pairs, with HOLD1 pending.
  - Response: all outputs 0. The next 4 pairs yield a sum containing no pre-reset contribution.
